// File: rtl/fe_pkg.sv
// Shared definitions for the fetch/execute front end: ALUOp and funct codes,
// the internal ALU operation set, the PC reset value and the ALU-control decode.
package fe_pkg;

   localparam logic [31:0] PC_RESET = 32'h0000_0000;

   // ALUOp codes driven by main control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // funct[3:0] codes of R-type instructions
   localparam logic [3:0] FUNCT_ADD  = 4'b0000;
   localparam logic [3:0] FUNCT_SUB  = 4'b0010;
   localparam logic [3:0] FUNCT_AND  = 4'b0100;
   localparam logic [3:0] FUNCT_OR   = 4'b0101;
   localparam logic [3:0] FUNCT_XOR  = 4'b0110;
   localparam logic [3:0] FUNCT_NOR  = 4'b0111;
   localparam logic [3:0] FUNCT_SLT  = 4'b1010;
   localparam logic [3:0] FUNCT_SLTU = 4'b1011;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU
   } alu_op_e;

   // ALU control: reserved ALUOp and unknown funct codes fall back to add
   function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [3:0] funct);
      alu_op_e op;
      op = ALU_ADD;
      if (aluop == ALUOP_SUB) begin
         op = ALU_SUB;
      end else if (aluop == ALUOP_RTYPE) begin
         case (funct)
            FUNCT_SUB:  op = ALU_SUB;
            FUNCT_AND:  op = ALU_AND;
            FUNCT_OR:   op = ALU_OR;
            FUNCT_XOR:  op = ALU_XOR;
            FUNCT_NOR:  op = ALU_NOR;
            FUNCT_SLT:  op = ALU_SLT;
            FUNCT_SLTU: op = ALU_SLTU;
            default:    op = ALU_ADD;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/fetch_execute_if.sv
// Bus between the fetch/execute front end and the surrounding datapath
// (register file, main control). There is no handshake: every signal is
// sampled combinationally and the PC advances on every rising clock edge.
interface fetch_execute_if;

   logic        Jump;
   logic        ALUSrc;
   logic        Branch;
   logic [1:0]  ALUOp;
   logic [3:0]  FunctC;
   logic [31:0] signExnd;
   logic [31:0] mem1Read;
   logic [31:0] mem2Read;
   logic [31:0] inst;
   logic [31:0] currentAddr;
   logic [31:0] ALUResult;
   logic [31:0] BranchMuxResult;
   logic        Zero;

   // surrounding datapath side
   modport master (
      output Jump, ALUSrc, Branch, ALUOp, FunctC, signExnd, mem1Read, mem2Read,
      input  inst, currentAddr, ALUResult, BranchMuxResult, Zero
   );

   // front-end side
   modport slave (
      input  Jump, ALUSrc, Branch, ALUOp, FunctC, signExnd, mem1Read, mem2Read,
      output inst, currentAddr, ALUResult, BranchMuxResult, Zero
   );

endinterface

// File: rtl/fe_alu.sv
// 32-bit ALU: arithmetic wraps modulo 2^32, comparisons return 1/0.
module fe_alu
   import fe_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     op,
   output logic [31:0] result,
   output logic        zero
);

   // operation select and zero flag
   always_comb begin
      result = a + b;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {31'd0, (a < b)};
         default:  result = a + b;
      endcase
      zero = (result == 32'd0);
   end

endmodule

// File: rtl/fetch_execute.sv
// Single-cycle MIPS front end: PC, instruction ROM, jump logic, ALU,
// branch-target adder and branch mux. The PC is the only state element.
module fetch_execute
  import fe_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter     IMEM_FILE  = ""
) (
  input  logic           clk,
  input  logic           reset,
  fetch_execute_if.slave bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] rom [IMEM_DEPTH];
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst_w;
  logic [31:0] branch_target;
  logic [31:0] bmux;
  logic [31:0] next_pc;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  alu_op_e     alu_op;

  // ROM starts with every word a nop
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = 32'd0;
  end

  // program counter: reset wins, otherwise take the selected next PC
  always_ff @(posedge clk) begin
    if (reset) pc <= PC_RESET;
    else       pc <= next_pc;
  end

  // fetch, branch and jump selection; jump overrides a taken branch
  always_comb begin
    pc4           = pc + 32'd4;
    inst_w        = rom[pc[AW+1:2]];
    alu_b         = bus.ALUSrc ? bus.signExnd : bus.mem2Read;
    alu_op        = alu_decode(bus.ALUOp, bus.FunctC);
    branch_target = pc4 + (bus.signExnd << 2);
    bmux          = (bus.Branch && alu_zero) ? branch_target : pc4;
    next_pc       = bus.Jump ? {pc4[31:28], inst_w[25:0], 2'b00} : bmux;
  end

  fe_alu u_alu (
    .a      (bus.mem1Read),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign bus.inst            = inst_w;
  assign bus.currentAddr     = pc;
  assign bus.ALUResult       = alu_result;
  assign bus.BranchMuxResult = bmux;
  assign bus.Zero            = alu_zero;

endmodule

// File: tb/tb_fetch_execute.sv
// Bench for fetch_execute: directed steps for the documented corner cases,
// then randomized cycles compared against a behavioural model of the PC,
// ROM and ALU kept here.
module tb_fetch_execute;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fetch_execute_if bus ();

   fetch_execute #(
      .IMEM_DEPTH (256),
      .IMEM_FILE  ("")
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] model_rom [256];
   logic [31:0] model_pc;

   // current stimulus, kept locally so the model never reads the DUT
   logic        s_jump, s_alusrc, s_branch;
   logic [1:0]  s_aluop;
   logic [3:0]  s_funct;
   logic [31:0] s_se, s_m1, s_m2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference ALU straight from the operation table
   function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [3:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      if (aluop == 2'b01) return a - b;
      if (aluop != 2'b10) return a + b;
      case (f)
         4'b0010: return a - b;
         4'b0100: return a & b;
         4'b0101: return a | b;
         4'b0110: return a ^ b;
         4'b0111: return ~(a | b);
         4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1011: return (a < b) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   task automatic drive(input logic j, input logic as, input logic br, input logic [1:0] op,
                        input logic [3:0] f, input logic [31:0] se, input logic [31:0] m1,
                        input logic [31:0] m2);
      s_jump = j; s_alusrc = as; s_branch = br; s_aluop = op;
      s_funct = f; s_se = se; s_m1 = m1; s_m2 = m2;
      bus.Jump = j; bus.ALUSrc = as; bus.Branch = br; bus.ALUOp = op;
      bus.FunctC = f; bus.signExnd = se; bus.mem1Read = m1; bus.mem2Read = m2;
   endtask

   // one clock cycle: check every output against the model, clock, check the new PC
   task automatic step(input logic rst);
      logic [31:0] exp_inst, pc4, exp_alu, exp_bmux, exp_next;
      logic        exp_zero;
      reset = rst;
      #1;
      exp_inst = model_rom[model_pc[9:2]];
      pc4      = model_pc + 32'd4;
      exp_alu  = ref_alu(s_aluop, s_funct, s_m1, s_alusrc ? s_se : s_m2);
      exp_zero = (exp_alu == 32'd0);
      exp_bmux = (s_branch && exp_zero) ? pc4 + s_se * 32'd4 : pc4;
      if (rst)         exp_next = 32'd0;
      else if (s_jump) exp_next = {pc4[31:28], exp_inst[25:0], 2'b00};
      else             exp_next = exp_bmux;
      check("currentAddr", bus.currentAddr, model_pc);
      check("inst", bus.inst, exp_inst);
      check("ALUResult", bus.ALUResult, exp_alu);
      check("Zero", {31'd0, bus.Zero}, {31'd0, exp_zero});
      check("BranchMuxResult", bus.BranchMuxResult, exp_bmux);
      @(posedge clk);
      #1;
      model_pc = exp_next;
      check("next_pc", bus.currentAddr, model_pc);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_pc = 32'd0;
      check("reset_pc", bus.currentAddr, 32'd0);
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 2'b01, 4'd0, 32'd0, 32'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      nop();
      model_pc = 32'd0;
      #1;
      // ROM preload: random words, with a jump at byte address 0x10
      for (int i = 0; i < 256; i++) model_rom[i] = $urandom;
      model_rom[4] = 32'h0800_0040;
      for (int i = 0; i < 256; i++) dut.rom[i] = model_rom[i];

      // reset held for two edges
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_pc", bus.currentAddr, 32'd0);

      // sequential fetch 0,4,8,12
      step(1'b0);
      check("seq_4", bus.currentAddr, 32'd4);
      step(1'b0);
      check("seq_8", bus.currentAddr, 32'd8);
      step(1'b0);
      check("seq_12", bus.currentAddr, 32'd12);

      // branch taken from PC 8
      do_reset();
      step(1'b0);
      step(1'b0);
      drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 32'd3, 32'd5, 32'd5);
      #1;
      check("br_zero", {31'd0, bus.Zero}, 32'd1);
      check("br_bmux", bus.BranchMuxResult, 32'd24);
      step(1'b0);
      check("br_taken_pc", bus.currentAddr, 32'd24);

      // branch not taken from PC 8
      do_reset();
      nop();
      step(1'b0);
      step(1'b0);
      drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 32'd3, 32'd5, 32'd6);
      step(1'b0);
      check("br_not_taken_pc", bus.currentAddr, 32'd12);

      // jump at PC 0x10
      nop();
      step(1'b0);
      check("pc_16", bus.currentAddr, 32'h10);
      drive(1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 32'd0, 32'd1, 32'd2);
      step(1'b0);
      check("jump_pc", bus.currentAddr, 32'h100);

      // jump beats a taken branch
      do_reset();
      nop();
      repeat (4) step(1'b0);
      drive(1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 32'd3, 32'd5, 32'd5);
      step(1'b0);
      check("jump_over_branch", bus.currentAddr, 32'h100);

      // R-type corners with A=-1, B=1
      drive(1'b0, 1'b0, 1'b0, 2'b10, 4'b0000, 32'd0, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("rt_add", bus.ALUResult, 32'd0);
      check("rt_add_zero", {31'd0, bus.Zero}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 4'b1010, 32'd0, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("rt_slt", bus.ALUResult, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 4'b1011, 32'd0, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("rt_sltu", bus.ALUResult, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 4'b0111, 32'd0, 32'hFFFF_FFFF, 32'd1);
      #1;
      check("rt_nor", bus.ALUResult, 32'd0);
      step(1'b0);

      // immediate operand with negative offset
      drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 32'hFFFF_FFFC, 32'd10, 32'd99);
      #1;
      check("imm_add", bus.ALUResult, 32'd6);
      step(1'b0);

      // reset asserted mid-run at PC 0x20
      do_reset();
      nop();
      repeat (8) step(1'b0);
      check("pc_32", bus.currentAddr, 32'h20);
      step(1'b1);
      check("mid_reset_pc", bus.currentAddr, 32'd0);

      // backward branch to 0xFFFF_FFFC, then wrap to 0
      drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 32'hFFFF_FFFE, 32'd7, 32'd7);
      step(1'b0);
      check("pc_top", bus.currentAddr, 32'hFFFF_FFFC);
      nop();
      step(1'b0);
      check("pc_wrap", bus.currentAddr, 32'd0);

      // randomized cycles
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)), a, b);
         step($urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
